// File: rtl/wishbone_slave_param_pkg.sv
// Shared types for the Wishbone slave: FSM states, access targets and default widths.
package wishbone_slave_param_pkg;

  localparam int DEF_DATA_W = 128;
  localparam int DEF_ADR_W  = 5;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_REQ,
    ST_WAIT,
    ST_ACK,
    ST_ERR,
    ST_HOLD
  } state_e;

  typedef enum logic [1:0] {
    TGT_NONE,
    TGT_REG,
    TGT_FIFO
  } tgt_e;

  // Timeout counter width; a disabled timeout still keeps a 1-bit counter.
  function automatic int cnt_width(input int timeout);
    return (timeout > 0) ? $clog2(timeout + 1) : 1;
  endfunction

endpackage

// File: rtl/wishbone_slave_param_wb_addr_decode.sv
// Maps a Wishbone word address onto the register window, the FIFO port or nothing.
module wb_addr_decode
  import wishbone_slave_param_pkg::*;
#(
  parameter int ADR_W    = DEF_ADR_W,
  parameter int NUM_REGS = 16,
  parameter int FIFO_ADR = 16
) (
  input  logic [ADR_W-1:0] adr_i,
  output tgt_e             tgt_o
);

  always_comb begin
    tgt_o = TGT_NONE;
    if (32'(adr_i) < 32'(NUM_REGS))       tgt_o = TGT_REG;
    else if (32'(adr_i) == 32'(FIFO_ADR)) tgt_o = TGT_FIFO;
  end

endmodule

// File: rtl/wishbone_slave_param.sv
// Wishbone slave bridging a master to the SD host register file and data FIFO,
// with cycle qualification, command decode and a host-response timeout.
module wishbone_slave_param
  import wishbone_slave_param_pkg::*;
#(
  parameter int DATA_W   = DEF_DATA_W,
  parameter int ADR_W    = DEF_ADR_W,
  parameter int NUM_REGS = 16,
  parameter int FIFO_ADR = 16,
  parameter int CMD_ADR  = 0,
  parameter int TIMEOUT  = 255
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              cyc_i,
  input  logic              strobe,
  input  logic              we_i,
  input  logic [ADR_W-1:0]  adr_i,
  input  logic [DATA_W-1:0] wb_data_i,
  input  logic [DATA_W-1:0] host_data_i,
  input  logic              cmd_done_i,
  input  logic              data_done_i,
  output logic [DATA_W-1:0] wb_data_o,
  output logic              ack_o,
  output logic              error_o,
  output logic [DATA_W-1:0] host_data_o,
  output logic              reg_read_en,
  output logic              reg_write_en,
  output logic              fifo_read_en,
  output logic              fifo_write_en,
  output logic              new_command,
  output logic              new_data
);

  localparam int CNT_W = cnt_width(TIMEOUT);

  state_e              state_q, state_d;
  tgt_e                tgt_q, tgt_d, dec_tgt;
  logic                we_q, we_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d, cnt_inc;
  logic [DATA_W-1:0]   wb_data_q, wb_data_d;
  logic [DATA_W-1:0]   host_data_q, host_data_d;
  logic                ack_q, ack_d, err_q, err_d;
  logic                rre_q, rre_d, rwe_q, rwe_d, fre_q, fre_d, fwe_q, fwe_d;
  logic                ncmd_q, ncmd_d, ndat_q, ndat_d;
  logic                is_cmd, done;

  wb_addr_decode #(
    .ADR_W    (ADR_W),
    .NUM_REGS (NUM_REGS),
    .FIFO_ADR (FIFO_ADR)
  ) u_dec (
    .adr_i (adr_i),
    .tgt_o (dec_tgt)
  );

  assign is_cmd  = (32'(adr_i) == 32'(CMD_ADR));
  assign done    = (tgt_q == TGT_REG)  ? cmd_done_i :
                   (tgt_q == TGT_FIFO) ? data_done_i : 1'b0;
  assign cnt_inc = (cnt_q == {CNT_W{1'b1}}) ? cnt_q : cnt_q + 1'b1;

  // Every output is computed one cycle ahead so it lands in the state it belongs to.
  always_comb begin
    state_d     = state_q;
    tgt_d       = tgt_q;
    we_d        = we_q;
    cnt_d       = cnt_q;
    wb_data_d   = wb_data_q;
    host_data_d = host_data_q;
    ack_d       = 1'b0;
    err_d       = 1'b0;
    rre_d       = 1'b0;
    rwe_d       = 1'b0;
    fre_d       = 1'b0;
    fwe_d       = 1'b0;
    ncmd_d      = 1'b0;
    ndat_d      = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (cyc_i && strobe) begin
          tgt_d = dec_tgt;
          we_d  = we_i;
          if (dec_tgt == TGT_NONE) begin
            state_d = ST_ERR;
            err_d   = 1'b1;
          end else begin
            state_d = ST_REQ;
            if (we_i) host_data_d = wb_data_i;
            rre_d  = (dec_tgt == TGT_REG)  && !we_i;
            rwe_d  = (dec_tgt == TGT_REG)  &&  we_i;
            fre_d  = (dec_tgt == TGT_FIFO) && !we_i;
            fwe_d  = (dec_tgt == TGT_FIFO) &&  we_i;
            ncmd_d = (dec_tgt == TGT_REG)  &&  we_i && is_cmd;
            ndat_d = (dec_tgt == TGT_FIFO) &&  we_i;
          end
        end
      end
      ST_REQ: begin
        cnt_d   = '0;
        state_d = cyc_i ? ST_WAIT : ST_IDLE;
      end
      ST_WAIT: begin
        if (!cyc_i) begin
          state_d = ST_IDLE;
        end else if (done) begin
          if (!we_q) wb_data_d = host_data_i;
          state_d = ST_ACK;
          ack_d   = 1'b1;
        end else begin
          cnt_d = cnt_inc;
          if ((TIMEOUT != 0) && (cnt_inc == CNT_W'(TIMEOUT))) begin
            state_d = ST_ERR;
            err_d   = 1'b1;
          end
        end
      end
      ST_ACK:  state_d = ST_HOLD;
      ST_ERR:  state_d = ST_HOLD;
      // Wait for the master to release the strobe so one strobe means one transfer.
      ST_HOLD: if (!strobe || !cyc_i) state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      tgt_q       <= TGT_NONE;
      we_q        <= 1'b0;
      cnt_q       <= '0;
      wb_data_q   <= '0;
      host_data_q <= '0;
      ack_q       <= 1'b0;
      err_q       <= 1'b0;
      rre_q       <= 1'b0;
      rwe_q       <= 1'b0;
      fre_q       <= 1'b0;
      fwe_q       <= 1'b0;
      ncmd_q      <= 1'b0;
      ndat_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      tgt_q       <= tgt_d;
      we_q        <= we_d;
      cnt_q       <= cnt_d;
      wb_data_q   <= wb_data_d;
      host_data_q <= host_data_d;
      ack_q       <= ack_d;
      err_q       <= err_d;
      rre_q       <= rre_d;
      rwe_q       <= rwe_d;
      fre_q       <= fre_d;
      fwe_q       <= fwe_d;
      ncmd_q      <= ncmd_d;
      ndat_q      <= ndat_d;
    end
  end

  assign wb_data_o     = wb_data_q;
  assign host_data_o   = host_data_q;
  assign ack_o         = ack_q;
  assign error_o       = err_q;
  assign reg_read_en   = rre_q;
  assign reg_write_en  = rwe_q;
  assign fifo_read_en  = fre_q;
  assign fifo_write_en = fwe_q;
  assign new_command   = ncmd_q;
  assign new_data      = ndat_q;

endmodule

// File: doc/wishbone_slave_param.md
Name: wishbone_slave_param

Overview:
Parametrised Wishbone slave that bridges a Wishbone master to the SD host core's register file and data FIFO. Address space is split into a register window, a FIFO port, and an unmapped region. The block adds cycle qualification (cyc_i), a command-register decode and a host-response timeout to the previous fixed-width slave. It sits between the Wishbone interconnect and the host command/data engines.

Parameters:
DATA_W, 128, width of Wishbone and host data paths
ADR_W, 5, Wishbone address width
NUM_REGS, 16, addresses 0..NUM_REGS-1 map to the register window
FIFO_ADR, 16, single address mapped to the data FIFO port (must be >= NUM_REGS)
CMD_ADR, 0, register address whose write is a new command
TIMEOUT, 255, cycles to wait for host done before error; 0 disables the timeout

Ports:
clock  in  1  system clock
reset  in  1  asynchronous, active-high reset
cyc_i  in  1  Wishbone bus cycle valid
strobe  in  1  Wishbone strobe
we_i  in  1  1 = write, 0 = read
adr_i  in  ADR_W  word address
wb_data_i  in  DATA_W  write data from master
host_data_i  in  DATA_W  read data from host
cmd_done_i  in  1  host completed register access
data_done_i  in  1  host completed FIFO access
wb_data_o  out  DATA_W  read data to master
ack_o  out  1  transfer acknowledge, 1-cycle pulse
error_o  out  1  transfer error, 1-cycle pulse
host_data_o  out  DATA_W  write data to host
reg_read_en  out  1  register read request pulse
reg_write_en  out  1  register write request pulse
fifo_read_en  out  1  FIFO read request pulse
fifo_write_en  out  1  FIFO write request pulse
new_command  out  1  pulse with reg_write_en when address == CMD_ADR
new_data  out  1  pulse with fifo_write_en

Behaviour:
- Reset: all outputs 0, wb_data_o and host_data_o 0, state IDLE, timeout counter 0. Reset mid-transaction aborts it with no ack or error.
- All outputs are registered.
- States: IDLE, REQ, WAIT, ACK, ERR, HOLD.
- IDLE: when cyc_i & strobe, latch adr_i, we_i and wb_data_i, then decode:
  - adr < NUM_REGS: register target.
  - adr == FIFO_ADR: FIFO target.
  - Otherwise: go to ERR.
  - Valid targets go to REQ.
- REQ (1 cycle): pulse exactly one of the four enables according to target and we. host_data_o = latched write data; it holds until the next write transaction. Pulse new_command or new_data in the same cycle as its enable, when applicable. Next state is WAIT; clear the counter.
- WAIT: the done source is cmd_done_i for register targets and data_done_i for FIFO targets. The other done input is ignored. Done is sampled only in WAIT; a done asserted during REQ is ignored.
  - Done seen on a read: capture host_data_i into wb_data_o, go to ACK.
  - Done seen on a write: go to ACK.
  - No done: increment the counter. If TIMEOUT != 0 and the counter reaches TIMEOUT, go to ERR.
- ACK: ack_o = 1 for 1 cycle, then HOLD. wb_data_o holds its value until the next read completion.
- ERR: error_o = 1 for 1 cycle, ack_o = 0, wb_data_o unchanged, then HOLD.
- HOLD: return to IDLE once strobe == 0 or cyc_i == 0. This prevents a held strobe from starting a second transfer.
- Abort: if cyc_i = 0 in REQ or WAIT, go to IDLE with no ack or error. A late done is ignored. Enables already pulsed are not retracted.
- Latency:
  - Request sampled at cycle N; enable at N+1.
  - Earliest done at N+2; ack_o at N+3.
  - Unmapped address gives error_o at N+1.
- Counter width: clog2(TIMEOUT+1), minimum 1; it saturates and never wraps.

Decomposition:
- Shared package holds: state encoding constants (IDLE..HOLD), target type constants (TGT_REG, TGT_FIFO, TGT_NONE), default widths.
- One natural sub-module: wb_addr_decode, a combinational decoder mapping adr_i to a target using NUM_REGS and FIFO_ADR.
- FSM, counter and datapath registers stay in the top module.

Test Plan:
- Register write: adr=3, we=1, wb_data_i=0xA5.., cmd_done_i 2 cycles after reg_write_en.
  -> reg_write_en 1 pulse; host_data_o=0xA5..; ack_o 1 pulse; new_command=0.
- Command write: adr=0 (CMD_ADR), we=1.
  -> reg_write_en and new_command pulse together; ack_o after cmd_done_i.
- FIFO read: adr=16, we=0, host_data_i=0x1234 with data_done_i.
  -> fifo_read_en pulse; wb_data_o=0x1234 when ack_o is asserted; stray cmd_done_i during WAIT is ignored.
- Unmapped access: adr=20.
  -> error_o at N+1; no enable pulses; ack_o stays 0.
- Timeout with TIMEOUT=8: register read with no cmd_done_i.
  -> error_o exactly 8 cycles into WAIT; back to IDLE after strobe drops.
- Abort and reset:
  - Drop cyc_i in WAIT, then a late cmd_done_i -> no ack or error.
  - Assert reset during WAIT -> all outputs 0 immediately.
  - Strobe held high after ack -> no second enable pulse.
